// File: rtl/frame_ser_pkg.sv
// Shared state type, CRC constants and counter sizing for the frame serializer.
package frame_ser_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    PAYLOAD,
    FCS
  } ser_state_t;

  // CRC-16/KERMIT: reflected form of x^16+x^12+x^5+1, zero init
  localparam logic [15:0] CRC_POLY = 16'h8408;
  localparam logic [15:0] CRC_INIT = 16'h0000;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/byte_fifo_sync.sv
// Byte FIFO with occupancy count; head byte is visible on rd_data without a read strobe.
module byte_fifo_sync #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic          do_wr;
  logic          do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign full    = (level_reg == LW'(DEPTH));
  assign empty   = (level_reg == '0);
  assign level   = level_reg;
  assign rd_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_rd) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/frame_serializer_fifo.sv
// Byte-in, bit-out transmit framer: preamble, SFD, PHR+PSDU and, with FRAME_CRC_EN
// defined, a trailing CRC-16/KERMIT FCS over the PSDU.
module frame_serializer_fifo #(
  parameter int                   DEPTH          = 16,
  parameter int                   PREAMBLE_BYTES = 8,
  parameter logic [7:0]           PREAMBLE_BYTE  = 8'hAA,
  parameter int                   SFD_WIDTH      = 16,
  parameter logic [SFD_WIDTH-1:0] SFD            = 16'hF398,
  parameter bit                   LSB_FIRST      = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   out_bit,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   frame_start,
  output logic                   frame_end,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  import frame_ser_pkg::*;

  localparam int PRE_BITS = PREAMBLE_BYTES * 8;
  localparam int SEG_MAX  = (PRE_BITS > SFD_WIDTH) ? PRE_BITS : SFD_WIDTH;
  localparam int CNT_MAX  = (SEG_MAX > 16) ? SEG_MAX : 16;
  localparam int CW       = cnt_width(CNT_MAX);
  localparam int VEC_W    = 2 ** CW;
  localparam logic [VEC_W-1:0] SFD_VEC = VEC_W'(SFD);

  ser_state_t    state_reg, state_next;
  logic [CW-1:0] bit_cnt_reg, bit_cnt_next;
  logic [8:0]    byte_cnt_reg, byte_cnt_next;
  logic          out_bit_reg, out_bit_next;
  logic          out_valid_reg, out_valid_next;
  logic          frame_start_reg, frame_start_next;
  logic          frame_end_reg, frame_end_next;
  logic [7:0]    head;
  logic          push;
  logic          pop;
  logic          advance;
  logic [2:0]    bit_idx;
  logic          payload_bit;

`ifdef FRAME_CRC_EN
  logic [15:0]   crc_reg, crc_next;
  logic          psdu_reg, psdu_next;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction
`endif

  assign in_ready    = !full;
  assign push        = in_valid && !full;
  assign out_bit     = out_bit_reg;
  assign out_valid   = out_valid_reg;
  assign frame_start = frame_start_reg;
  assign frame_end   = frame_end_reg;

  byte_fifo_sync #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (push),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  // The output register reloads whenever it is empty or its bit is being taken
  assign advance     = !out_valid_reg || out_ready;
  assign bit_idx     = bit_cnt_reg[2:0];
  assign payload_bit = LSB_FIRST ? head[bit_idx] : head[3'd7 - bit_idx];

  always_comb begin
    state_next       = state_reg;
    bit_cnt_next     = bit_cnt_reg;
    byte_cnt_next    = byte_cnt_reg;
    out_bit_next     = out_bit_reg;
    out_valid_next   = out_valid_reg;
    frame_start_next = frame_start_reg;
    frame_end_next   = frame_end_reg;
    pop              = 1'b0;
`ifdef FRAME_CRC_EN
    crc_next         = crc_reg;
    psdu_next        = psdu_reg;
`endif
    if (advance) begin
      out_valid_next   = 1'b0;
      frame_start_next = 1'b0;
      frame_end_next   = 1'b0;
      case (state_reg)
        IDLE: begin
          // Waiting for an empty output register guarantees one idle cycle between frames
          if (!out_valid_reg && !empty) begin
            out_valid_next   = 1'b1;
            out_bit_next     = PREAMBLE_BYTE[0];
            frame_start_next = 1'b1;
            byte_cnt_next    = {1'b0, head} + 9'd1;
            bit_cnt_next     = CW'(1);
            state_next       = PREAMBLE;
`ifdef FRAME_CRC_EN
            crc_next         = CRC_INIT;
            psdu_next        = 1'b0;
`endif
          end
        end
        PREAMBLE: begin
          out_valid_next = 1'b1;
          out_bit_next   = PREAMBLE_BYTE[bit_idx];
          if (bit_cnt_reg == CW'(PRE_BITS - 1)) begin
            bit_cnt_next = '0;
            state_next   = frame_ser_pkg::SFD;
          end else begin
            bit_cnt_next = bit_cnt_reg + CW'(1);
          end
        end
        frame_ser_pkg::SFD: begin
          out_valid_next = 1'b1;
          out_bit_next   = SFD_VEC[bit_cnt_reg];
          if (bit_cnt_reg == CW'(SFD_WIDTH - 1)) begin
            bit_cnt_next = '0;
            state_next   = PAYLOAD;
          end else begin
            bit_cnt_next = bit_cnt_reg + CW'(1);
          end
        end
        PAYLOAD: begin
          // A byte boundary with nothing queued is an underrun: stall without leaving PAYLOAD
          if (bit_idx != 3'd0 || !empty) begin
            out_valid_next = 1'b1;
            out_bit_next   = payload_bit;
            if (bit_idx == 3'd7) begin
              pop           = 1'b1;
              bit_cnt_next  = '0;
              byte_cnt_next = byte_cnt_reg - 9'd1;
`ifdef FRAME_CRC_EN
              psdu_next     = 1'b1;
              if (psdu_reg) begin
                crc_next = crc16_byte(crc_reg, head);
              end
`endif
              if (byte_cnt_reg == 9'd1) begin
`ifdef FRAME_CRC_EN
                state_next     = FCS;
`else
                frame_end_next = 1'b1;
                state_next     = IDLE;
`endif
              end
            end else begin
              bit_cnt_next = bit_cnt_reg + CW'(1);
            end
          end
        end
`ifdef FRAME_CRC_EN
        FCS: begin
          out_valid_next = 1'b1;
          out_bit_next   = crc_reg[bit_cnt_reg[3:0]];
          if (bit_cnt_reg == CW'(15)) begin
            bit_cnt_next   = '0;
            frame_end_next = 1'b1;
            state_next     = IDLE;
          end else begin
            bit_cnt_next = bit_cnt_reg + CW'(1);
          end
        end
`endif
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      bit_cnt_reg     <= '0;
      byte_cnt_reg    <= '0;
      out_bit_reg     <= 1'b0;
      out_valid_reg   <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_end_reg   <= 1'b0;
`ifdef FRAME_CRC_EN
      crc_reg         <= CRC_INIT;
      psdu_reg        <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      bit_cnt_reg     <= bit_cnt_next;
      byte_cnt_reg    <= byte_cnt_next;
      out_bit_reg     <= out_bit_next;
      out_valid_reg   <= out_valid_next;
      frame_start_reg <= frame_start_next;
      frame_end_reg   <= frame_end_next;
`ifdef FRAME_CRC_EN
      crc_reg         <= crc_next;
      psdu_reg        <= psdu_next;
`endif
    end
  end

endmodule

// File: doc/frame_serializer_fifo.md
Name: frame_serializer_fifo

Overview:
Byte-in, bit-out transmit framer for the PHY encoding path. It buffers PHR+PSDU bytes in a parametrised FIFO and, per frame, emits a configurable preamble, then the SFD, then PHR and PSDU bits. Compared with the previous framer it adds parametrised depth, preamble and SFD, valid/ready handshakes on both sides, underrun stall, frame markers and optional FCS insertion. It sits between the MAC byte stream and the bit-level spreading/modulation stage.

Parameters:
DEPTH, 16, FIFO depth in bytes; power of 2, at least 4.
PREAMBLE_BYTES, 8, number of preamble bytes per frame, at least 1.
PREAMBLE_BYTE, 8'hAA, value of each preamble byte.
SFD_WIDTH, 16, SFD length in bits, multiple of 8.
SFD, 16'hF398, SFD value; bit 0 is sent first.
LSB_FIRST, 1, bit order for PHR/PSDU/FCS bytes; 1 sends bit 0 first, 0 sends bit 7 first. Preamble and SFD are always sent LSB first.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  reset, asynchronous, active-low
in_data  in  8  byte to enqueue; the first byte of each frame is the PHR, i.e. PSDU length L
in_valid  in  1  in_data valid
in_ready  out  1  equals !full
out_bit  out  1  serial bit
out_valid  out  1  out_bit valid
out_ready  in  1  downstream accepts out_bit
frame_start  out  1  high with the first preamble bit
frame_end  out  1  high with the last bit of the frame
full  out  1  level == DEPTH
empty  out  1  level == 0
level  out  $clog2(DEPTH)+1  bytes stored

Behaviour:
- Reset (asynchronous, takes effect mid-frame too): FIFO empty, pointers 0, state IDLE. Output values at reset: out_bit=0, out_valid=0, frame_start=0, frame_end=0, in_ready=1, full=0, empty=1, level=0.
- Push: occurs when in_valid && in_ready. No write-through: a push into a full FIFO is impossible and a push with in_ready=0 is ignored.
- Pop: occurs when the serializer has consumed the last bit of a byte.
- Simultaneous push and pop: level is unchanged. Pointers wrap modulo DEPTH.
- Output stage is registered. A bit transfers on out_valid && out_ready. While out_valid=1 and out_ready=0, out_bit, frame_start and frame_end hold stable.
- FSM states:
  - IDLE: out_valid=0. Goes to PREAMBLE when !empty. First preamble bit is valid on the 2nd rising edge after the PHR handshake into an empty FIFO.
  - PREAMBLE: PREAMBLE_BYTES*8 bits. PHR is latched from the FIFO head (9-bit byte counter = L+1) on entry.
  - SFD: SFD_WIDTH bits.
  - PAYLOAD: (L+1)*8 bits, PHR first. L=0 sends the PHR only; L=255 sends 256 bytes.
  - FCS: only when FRAME_CRC_EN is defined; see below.
  - Last frame state returns to IDLE, giving one idle cycle with out_valid=0 before the next frame.
- Underrun: if the FIFO is empty when a new payload byte is needed, out_valid=0 and the FSM holds in PAYLOAD. It resumes from the next byte when data arrives; preamble and SFD are not repeated.
- Bytes pushed after the current frame's data are held in the FIFO and become the next frame's PHR.

Optional Feature:
FRAME_CRC_EN:
- Defined: adds state FCS after PAYLOAD. Sends a 16-bit CRC (poly x^16+x^12+x^5+1, reflected, init 0, i.e. CRC-16/KERMIT) computed over the PSDU bytes only, excluding PHR. The low byte is sent first, each byte LSB first regardless of LSB_FIRST. L counts PSDU bytes excluding FCS. frame_end is asserted on the last FCS bit.
- Undefined: no FCS state and no CRC logic; frame_end is asserted on the last payload bit.

Decomposition:
- Package frame_ser_pkg holds: the state enum (IDLE, PREAMBLE, SFD, PAYLOAD, FCS), the CRC polynomial and init constants, and the bit-counter width function.
- Sub-module byte_fifo_sync holds the storage, pointers, level, full and empty. The FSM, shifter and CRC stay in the top module.

Test Plan:
- Push 0x01, 0x5A with out_ready=1 -> 64 bits of 0,1 repeating; then 0,0,0,1,1,0,0,1 (0x98); then 1,1,0,0,1,1,1,1 (0xF3); then 0x01 LSB first; then 0x5A LSB first. Total 96 bits; frame_start on bit 1, frame_end on bit 96; then out_valid=0.
- Same frame with out_ready toggling pseudo-randomly -> identical accepted bit sequence; out_bit stable while stalled.
- out_ready=0, push 20 bytes -> full=1, in_ready=0 after the 16th; level=16; bytes 17-20 ignored. Release -> exactly 16 bytes drained.
- Push PHR 0x03 and one PSDU byte -> after 16 payload bits out_valid=0, state PAYLOAD. Push 2 more bytes -> resumes with no preamble repeat; total 64+16+32 bits.
- Two back-to-back frames preloaded -> exactly one out_valid=0 cycle between them. Assert reset_n mid-PREAMBLE of the second frame -> out_valid=0, level=0 immediately.
- FRAME_CRC_EN, PHR=0x09, PSDU "123456789" -> FCS bytes 0x89 then 0x21 after the PSDU; frame_end on the final FCS bit.
